ex_operand_issue: RTL

ID/EX issue stage of the data-forwarding RV32I pipeline. Decodes the instruction in ID into a 6-bit ALU control code and holds it with its register operands in the ID/EX register. In EX it drives the ALU's `ALU_Control`, `operand_A` and `operand_B`, applying EX/MEM and MEM/WB forwarding. It also detects load-use hazards and inserts one bubble for each.

---
 rtl/ex_operand_issue.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_operand_issue.sv
// ex_operand_issue
// ID/EX issue stage of the RV32I forwarding pipeline.
// Decodes the ID instruction into an ALU control code and captures it into the ID/EX register.
// Supplies forwarded ALU operands in EX and inserts one bubble for each load-use hazard.
module ex_operand_issue #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_instr,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic [4:0]        ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic              ex_mem_is_load,
    input  logic [XLEN-1:0]   ex_mem_result,
    input  logic [4:0]        mem_wb_rd,
    input  logic              mem_wb_regwrite,
    input  logic [XLEN-1:0]   mem_wb_result,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ALU_Control,
    output logic [XLEN-1:0]   operand_A,
    output logic [XLEN-1:0]   operand_B,
    output logic [4:0]        ex_rd,
    output logic              ex_regwrite,
    output logic              ex_is_load,
    output logic              ex_is_store,
    output logic              ex_illegal,
    output logic [XLEN-1:0]   ex_store_data
);

    localparam logic [CTRL_W-1:0] ALU_ADD  = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] ALU_SUB  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] ALU_SLL  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] ALU_SLT  = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] ALU_SLTU = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] ALU_XOR  = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] ALU_SRL  = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] ALU_SRA  = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] ALU_OR   = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] ALU_AND  = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] ALU_NOP  = CTRL_W'(6'h3F);

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // Source of operand A: forwarded rs1, constant zero (LUI) or the PC (AUIPC).
    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_ZERO = 2'd1,
        A_PC   = 2'd2
    } a_sel_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_field;
    logic [4:0] rs2_field;
    logic [4:0] rd_field;

    assign opcode    = id_instr[6:0];
    assign rd_field  = id_instr[11:7];
    assign funct3    = id_instr[14:12];
    assign rs1_field = id_instr[19:15];
    assign rs2_field = id_instr[24:20];
    assign funct7    = id_instr[31:25];

    // Decoded ID instruction, before capture.
    logic [CTRL_W-1:0] base_op;
    logic [CTRL_W-1:0] d_ctrl;
    logic [4:0]        d_rd;
    logic              d_regwrite;
    logic              d_is_load;
    logic              d_is_store;
    logic              d_illegal;
    a_sel_t            d_a_sel;
    logic              d_b_imm;
    logic [XLEN-1:0]   d_imm;
    logic              d_use_rs1;
    logic              d_use_rs2;

    // ID/EX register contents.
    a_sel_t            ex_a_sel;
    logic              ex_b_imm;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_pc;
    logic [4:0]        ex_rs1_idx;
    logic [4:0]        ex_rs2_idx;
    logic [XLEN-1:0]   ex_rs1_val;
    logic [XLEN-1:0]   ex_rs2_val;

    logic              hazard;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;
    logic [XLEN-1:0]   b_raw;
    logic              is_shift;

    // Map funct3 to the ALU operation shared by R-type and I-type arithmetic.
    always_comb begin
        base_op = ALU_ADD;
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    // Full decode of the ID instruction; use flags are opcode based so the hazard check sees them even for bad funct7.
    always_comb begin
        d_ctrl     = ALU_NOP;
        d_rd       = 5'd0;
        d_regwrite = 1'b0;
        d_is_load  = 1'b0;
        d_is_store = 1'b0;
        d_illegal  = 1'b0;
        d_a_sel    = A_RS1;
        d_b_imm    = 1'b0;
        d_imm      = '0;
        d_use_rs1  = 1'b0;
        d_use_rs2  = 1'b0;
        case (opcode)
            OPC_R: begin
                d_use_rs1 = 1'b1;
                d_use_rs2 = 1'b1;
                if (funct7 == 7'b0000000) begin
                    d_ctrl = base_op;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    d_ctrl = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    d_ctrl = ALU_SRA;
                end else begin
                    d_illegal = 1'b1;
                end
                if (!d_illegal) begin
                    d_regwrite = 1'b1;
                    d_rd       = rd_field;
                end
            end
            OPC_I: begin
                d_use_rs1  = 1'b1;
                d_b_imm    = 1'b1;
                d_regwrite = 1'b1;
                d_rd       = rd_field;
                d_ctrl     = (funct3 == 3'b101 && id_instr[30]) ? ALU_SRA : base_op;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    d_imm = {{(XLEN-5){1'b0}}, id_instr[24:20]};
                end else begin
                    d_imm = {{(XLEN-11){id_instr[31]}}, id_instr[30:20]};
                end
            end
            OPC_LOAD: begin
                d_use_rs1  = 1'b1;
                d_b_imm    = 1'b1;
                d_ctrl     = ALU_ADD;
                d_is_load  = 1'b1;
                d_regwrite = 1'b1;
                d_rd       = rd_field;
                d_imm      = {{(XLEN-11){id_instr[31]}}, id_instr[30:20]};
            end
            OPC_STORE: begin
                d_use_rs1  = 1'b1;
                d_use_rs2  = 1'b1;
                d_b_imm    = 1'b1;
                d_ctrl     = ALU_ADD;
                d_is_store = 1'b1;
                d_imm      = {{(XLEN-11){id_instr[31]}}, id_instr[30:25], id_instr[11:7]};
            end
            OPC_LUI, OPC_AUIPC: begin
                d_a_sel    = (opcode == OPC_LUI) ? A_ZERO : A_PC;
                d_b_imm    = 1'b1;
                d_ctrl     = ALU_ADD;
                d_regwrite = 1'b1;
                d_rd       = rd_field;
                d_imm      = {{(XLEN-31){id_instr[31]}}, id_instr[30:12], 12'b0};
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
    end

    // A load in EX whose destination is read by the ID instruction cannot be forwarded in time.
    always_comb begin
        hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                 ((d_use_rs1 && rs1_field == ex_rd) || (d_use_rs2 && rs2_field == ex_rd));
    end

    assign id_ready = !flush && !ex_stall && !hazard;

    // ID/EX register: flush beats stall beats hazard bubble beats capture; anything else becomes a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset || flush || (!ex_stall && (hazard || !id_valid))) begin
            ex_valid    <= 1'b0;
            ALU_Control <= ALU_NOP;
            ex_rd       <= 5'd0;
            ex_regwrite <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_a_sel    <= A_RS1;
            ex_b_imm    <= 1'b0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            ex_rs1_idx  <= 5'd0;
            ex_rs2_idx  <= 5'd0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
        end else if (!ex_stall) begin
            ex_valid    <= 1'b1;
            ALU_Control <= d_ctrl;
            ex_rd       <= d_rd;
            ex_regwrite <= d_regwrite;
            ex_is_load  <= d_is_load;
            ex_is_store <= d_is_store;
            ex_illegal  <= d_illegal;
            ex_a_sel    <= d_a_sel;
            ex_b_imm    <= d_b_imm;
            ex_imm      <= d_imm;
            ex_pc       <= id_pc;
            ex_rs1_idx  <= (d_use_rs1 && !d_illegal) ? rs1_field : 5'd0;
            ex_rs2_idx  <= (d_use_rs2 && !d_illegal) ? rs2_field : 5'd0;
            ex_rs1_val  <= (d_use_rs1 && !d_illegal) ? rs1_data : '0;
            ex_rs2_val  <= (d_use_rs2 && !d_illegal) ? rs2_data : '0;
        end
    end

    // Forward each register source from EX/MEM (non-load) first, then MEM/WB; x0 never forwards.
    always_comb begin
        fwd_rs1 = ex_rs1_val;
        if (ex_rs1_idx != 5'd0 && ex_mem_regwrite && ex_mem_rd == ex_rs1_idx && !ex_mem_is_load) begin
            fwd_rs1 = ex_mem_result;
        end else if (ex_rs1_idx != 5'd0 && mem_wb_regwrite && mem_wb_rd == ex_rs1_idx) begin
            fwd_rs1 = mem_wb_result;
        end
        fwd_rs2 = ex_rs2_val;
        if (ex_rs2_idx != 5'd0 && ex_mem_regwrite && ex_mem_rd == ex_rs2_idx && !ex_mem_is_load) begin
            fwd_rs2 = ex_mem_result;
        end else if (ex_rs2_idx != 5'd0 && mem_wb_regwrite && mem_wb_rd == ex_rs2_idx) begin
            fwd_rs2 = mem_wb_result;
        end
    end

    // Select the ALU operands; shift amounts only keep their low five bits.
    always_comb begin
        case (ex_a_sel)
            A_ZERO:  operand_A = '0;
            A_PC:    operand_A = ex_pc;
            default: operand_A = fwd_rs1;
        endcase
        b_raw    = ex_b_imm ? ex_imm : fwd_rs2;
        is_shift = (ALU_Control == ALU_SLL) || (ALU_Control == ALU_SRL) || (ALU_Control == ALU_SRA);
        operand_B     = is_shift ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
        ex_store_data = fwd_rs2;
    end

endmodule
